// File: rtl/rs_param_queue_if.sv
// Dispatch / CDB / issue bundle between the core and one reservation station.
interface rs_param_queue_if #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned TAG_W  = 3,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned OP_W   = 5,
   parameter int unsigned PAY_W  = 33,
   parameter int unsigned N_CDB  = 2
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic                      flush;
   logic                      disp_valid;
   logic                      disp_ready;
   logic [OP_W-1:0]           disp_op;
   logic [TAG_W-1:0]          disp_dest;
   logic [TAG_W-1:0]          disp_q1;
   logic [TAG_W-1:0]          disp_q2;
   logic [DATA_W-1:0]         disp_v1;
   logic [DATA_W-1:0]         disp_v2;
   logic [PAY_W-1:0]          disp_pay;
   logic [N_CDB-1:0]          cdb_valid;
   logic [N_CDB*TAG_W-1:0]    cdb_tag;
   logic [N_CDB*DATA_W-1:0]   cdb_data;
   logic                      iss_valid;
   logic                      iss_ready;
   logic [OP_W-1:0]           iss_op;
   logic [TAG_W-1:0]          iss_dest;
   logic [DATA_W-1:0]         iss_v1;
   logic [DATA_W-1:0]         iss_v2;
   logic [PAY_W-1:0]          iss_pay;
   logic [CNT_W-1:0]          count;
   logic                      almost_full;

   modport master (
      output flush, disp_valid, disp_op, disp_dest, disp_q1, disp_q2, disp_v1, disp_v2, disp_pay,
             cdb_valid, cdb_tag, cdb_data, iss_ready,
      input  disp_ready, iss_valid, iss_op, iss_dest, iss_v1, iss_v2, iss_pay, count, almost_full
   );

   modport slave (
      input  flush, disp_valid, disp_op, disp_dest, disp_q1, disp_q2, disp_v1, disp_v2, disp_pay,
             cdb_valid, cdb_tag, cdb_data, iss_ready,
      output disp_ready, iss_valid, iss_op, iss_dest, iss_v1, iss_v2, iss_pay, count, almost_full
   );
endinterface

// File: rtl/rs_param_queue.sv
// Parametrised reservation station: holds ops until operands arrive via CDB snoop,
// issues the oldest ready entry through a valid/ready output register.
module rs_param_queue #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned TAG_W  = 3,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned OP_W   = 5,
   parameter int unsigned PAY_W  = 33,
   parameter int unsigned N_CDB  = 2,
   parameter int unsigned AFULL  = 1
) (
   input logic           clk,
   input logic           rst,
   rs_param_queue_if.slave bus
);
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic        AF_RST = (DEPTH <= AFULL);

   logic [DEPTH-1:0]  vld;
   logic [OP_W-1:0]   e_op   [DEPTH];
   logic [TAG_W-1:0]  e_dest [DEPTH];
   logic [TAG_W-1:0]  e_q1   [DEPTH];
   logic [TAG_W-1:0]  e_q2   [DEPTH];
   logic [DATA_W-1:0] e_v1   [DEPTH];
   logic [DATA_W-1:0] e_v2   [DEPTH];
   logic [PAY_W-1:0]  e_pay  [DEPTH];
   logic [DEPTH-1:0]  older  [DEPTH];   // older[i][j]: entry i was dispatched before entry j

   logic [CNT_W-1:0]  cnt;
   logic              af;
   logic              iss_valid_q;
   logic [OP_W-1:0]   iss_op_q;
   logic [TAG_W-1:0]  iss_dest_q;
   logic [DATA_W-1:0] iss_v1_q, iss_v2_q;
   logic [PAY_W-1:0]  iss_pay_q;

   logic [DEPTH-1:0]  rdy, blk;
   logic              sel_hit;
   logic [IDX_W-1:0]  sel_idx, free_idx;
   logic [DATA_W:0]   w1 [DEPTH];
   logic [DATA_W:0]   w2 [DEPTH];
   logic [DATA_W:0]   b1, b2;
   logic              disp_rdy_c, disp_acc, iss_fire, take;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              af_nxt;

   // Returns {hit, data}; the lowest-index matching channel wins, tag 0 never matches.
   function automatic logic [DATA_W:0] snoop(input logic [TAG_W-1:0]        q,
                                              input logic [N_CDB-1:0]        v,
                                              input logic [N_CDB*TAG_W-1:0]  t,
                                              input logic [N_CDB*DATA_W-1:0] d);
      logic [DATA_W:0] r;
      r = '0;
      for (int c = int'(N_CDB) - 1; c >= 0; c--)
         if (v[c] && (q != '0) && (t[c*TAG_W +: TAG_W] == q))
            r = {1'b1, d[c*DATA_W +: DATA_W]};
      return r;
   endfunction

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w1[i] = snoop(e_q1[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
         w2[i] = snoop(e_q2[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      end
      b1 = snoop(bus.disp_q1, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      b2 = snoop(bus.disp_q2, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++)
         rdy[i] = vld[i] && (e_q1[i] == '0) && (e_q2[i] == '0);
   end

   // Oldest-ready select via the age matrix, lowest free slot for dispatch.
   always_comb begin
      blk      = '0;
      sel_hit  = 1'b0;
      sel_idx  = '0;
      free_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         for (int j = 0; j < DEPTH; j++)
            if (rdy[j] && older[j][i]) blk[i] = 1'b1;
         if (rdy[i] && !blk[i]) begin
            sel_hit = 1'b1;
            sel_idx = IDX_W'(i);
         end
      end
      for (int i = int'(DEPTH) - 1; i >= 0; i--)
         if (!vld[i]) free_idx = IDX_W'(i);
   end

   assign disp_rdy_c = rst && (cnt < CNT_W'(DEPTH));
   assign disp_acc   = bus.disp_valid && disp_rdy_c && !bus.flush;
   assign iss_fire   = !iss_valid_q || bus.iss_ready;
   assign take       = iss_fire && sel_hit;
   assign cnt_nxt    = cnt + CNT_W'(disp_acc) - CNT_W'(take);
   assign af_nxt     = (CNT_W'(DEPTH) - cnt_nxt) <= CNT_W'(AFULL);

   // Control state: occupancy, flags and the issue register.
   always_ff @(posedge clk) begin
      if (!rst || bus.flush) begin
         vld         <= '0;
         cnt         <= '0;
         af          <= AF_RST;
         iss_valid_q <= 1'b0;
         iss_op_q    <= '1;
         iss_dest_q  <= '0;
         iss_v1_q    <= '0;
         iss_v2_q    <= '0;
         iss_pay_q   <= '0;
      end else begin
         if (take)     vld[sel_idx]  <= 1'b0;
         if (disp_acc) vld[free_idx] <= 1'b1;
         cnt <= cnt_nxt;
         af  <= af_nxt;
         if (iss_fire) begin
            if (sel_hit) begin
               iss_valid_q <= 1'b1;
               iss_op_q    <= e_op[sel_idx];
               iss_dest_q  <= e_dest[sel_idx];
               iss_v1_q    <= e_v1[sel_idx];
               iss_v2_q    <= e_v2[sel_idx];
               iss_pay_q   <= e_pay[sel_idx];
            end else begin
               iss_valid_q <= 1'b0;
               iss_op_q    <= '1;
            end
         end
      end
   end

   // Entry payload: CDB wakeup, then dispatch write (with same-cycle bypass) overrides.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (w1[i][DATA_W]) begin
            e_q1[i] <= '0;
            e_v1[i] <= w1[i][DATA_W-1:0];
         end
         if (w2[i][DATA_W]) begin
            e_q2[i] <= '0;
            e_v2[i] <= w2[i][DATA_W-1:0];
         end
      end
      if (disp_acc) begin
         e_op[free_idx]   <= bus.disp_op;
         e_dest[free_idx] <= bus.disp_dest;
         e_pay[free_idx]  <= bus.disp_pay;
         e_q1[free_idx]   <= b1[DATA_W] ? '0 : bus.disp_q1;
         e_v1[free_idx]   <= b1[DATA_W] ? b1[DATA_W-1:0] : bus.disp_v1;
         e_q2[free_idx]   <= b2[DATA_W] ? '0 : bus.disp_q2;
         e_v2[free_idx]   <= b2[DATA_W] ? b2[DATA_W-1:0] : bus.disp_v2;
         older[free_idx]  <= '0;
         for (int j = 0; j < DEPTH; j++)
            older[j][free_idx] <= vld[j];
      end
   end

   assign bus.disp_ready  = disp_rdy_c;
   assign bus.iss_valid   = iss_valid_q;
   assign bus.iss_op      = iss_op_q;
   assign bus.iss_dest    = iss_dest_q;
   assign bus.iss_v1      = iss_v1_q;
   assign bus.iss_v2      = iss_v2_q;
   assign bus.iss_pay     = iss_pay_q;
   assign bus.count       = cnt;
   assign bus.almost_full = af;
endmodule
